// File: rtl/srt4_pkg.sv
// Shared types and constants for the radix-4 SRT divider sequencer.
// Holds the FSM state encoding, control-pulse bit indices and quotient digit type.
// Digit helper functions map a latched digit onto its SHIFT / ADD control pulses.
package srt4_pkg;

    localparam int N_ITER_DEF   = 4;
    localparam int NORM_MAX_DEF = 7;
    localparam int NUM_C        = 15;

    // Control pulse indices: bit i of c is pulse ci
    localparam int C0  = 0;
    localparam int C1  = 1;
    localparam int C2  = 2;
    localparam int C3  = 3;
    localparam int C4  = 4;
    localparam int C5  = 5;
    localparam int C6  = 6;
    localparam int C7  = 7;
    localparam int C8  = 8;
    localparam int C9  = 9;
    localparam int C10 = 10;
    localparam int C11 = 11;
    localparam int C12 = 12;
    localparam int C13 = 13;
    localparam int C14 = 14;

    typedef logic [NUM_C-1:0] ctrl_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_NORM_CHK,
        S_NORM_SHIFT,
        S_SEL,
        S_SHIFT,
        S_ADD,
        S_CORR,
        S_QUOT,
        S_DENORM_CHK,
        S_DENORM_SHIFT,
        S_DONE
    } state_t;

    // Quotient digit in {-2,-1,0,+1,+2}, encoded as a 3-bit two's-complement value
    typedef enum logic [2:0] {
        DIG_ZERO = 3'b000,
        DIG_P1   = 3'b001,
        DIG_P2   = 3'b010,
        DIG_M2   = 3'b110,
        DIG_M1   = 3'b111
    } digit_t;

    // SHIFT cycle: c3 always, plus the digit bit that loads the quotient digit
    function automatic ctrl_t shift_bits(input digit_t d);
        ctrl_t b;
        b      = '0;
        b[C3]  = 1'b1;
        case (d)
            DIG_P1:  b[C4] = 1'b1;
            DIG_P2:  b[C7] = 1'b1;
            DIG_M1:  b[C5] = 1'b1;
            DIG_M2:  b[C6] = 1'b1;
            default: ;
        endcase
        return b;
    endfunction

    // ADD cycle: c8 clocks P, c9 selects subtract (positive digit), c10 selects 2B
    function automatic ctrl_t add_bits(input digit_t d);
        ctrl_t b;
        b = '0;
        case (d)
            DIG_P1: begin
                b[C8] = 1'b1;
                b[C9] = 1'b1;
            end
            DIG_P2: begin
                b[C8]  = 1'b1;
                b[C9]  = 1'b1;
                b[C10] = 1'b1;
            end
            DIG_M1: begin
                b[C8] = 1'b1;
            end
            DIG_M2: begin
                b[C8]  = 1'b1;
                b[C10] = 1'b1;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/srt4_qsel.sv
// Radix-4 quotient digit selection from the 4-bit partial remainder estimate P[8:5].
// Latency: purely combinational.
// Backpressure: none; the sequencer samples the digit only in its SEL state.
module srt4_qsel
    import srt4_pkg::*;
(
    input  logic [3:0] p_top,
    output digit_t     digit
);

    // Map the two's-complement estimate onto the redundant digit set
    always_comb begin
        digit = DIG_ZERO;
        case (p_top)
            4'h0, 4'hF:                      digit = DIG_ZERO;  //  0, -1
            4'h1:                            digit = DIG_P1;    // +1
            4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7:                      digit = DIG_P2;    // >= +2
            4'hE:                            digit = DIG_M1;    // -2
            default:                         digit = DIG_M2;    // <= -3
        endcase
    end

endmodule

// File: rtl/srt4_control.sv
// Sequencer for the radix-4 SRT divider: normalise, 4 iterations, correct, denormalise.
// Latency: done in cycle 18 + 4*norm_cnt after start (17 on divide-by-zero).
// Backpressure: none; start is sampled only in IDLE, all outputs are registered.
// Optional SRT4_CYCLE_COUNT_EN adds a cycle_cnt output counting busy cycles.
module srt4_control
    import srt4_pkg::*;
#(
    parameter int N_ITER   = N_ITER_DEF,
    parameter int NORM_MAX = NORM_MAX_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              b_msb,
    input  logic [3:0]        p_top,
    input  logic              p_sign,
    output logic [NUM_C-1:0]  c,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
`ifdef SRT4_CYCLE_COUNT_EN
    ,
    output logic [5:0]        cycle_cnt
`endif
);

    localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int CW = (NORM_MAX > 0) ? $clog2(NORM_MAX + 1) : 1;

    state_t          state_q, state_d;
    ctrl_t           c_q, c_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [CW-1:0]   norm_q, norm_d;
    logic [CW-1:0]   den_q, den_d;
    logic [IW-1:0]   iter_q, iter_d;
    digit_t          digit_q, digit_d;
    digit_t          sel_digit;
`ifdef SRT4_CYCLE_COUNT_EN
    logic [5:0]      cyc_q, cyc_d;
`endif

    srt4_qsel u_qsel (
        .p_top (p_top),
        .digit (sel_digit)
    );

    // Next state, counters, and the control pulses for the state being entered
    always_comb begin
        state_d = state_q;
        dbz_d   = dbz_q;
        norm_d  = norm_q;
        den_d   = den_q;
        iter_d  = iter_q;
        digit_d = digit_q;
        c_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    norm_d  = '0;
                    iter_d  = '0;
                    dbz_d   = 1'b0;
                end
            end
            S_INIT:       state_d = S_NORM_CHK;
            S_NORM_CHK: begin
                if (b_msb) begin
                    state_d = S_SEL;
                end else if (norm_q == CW'(NORM_MAX)) begin
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_NORM_SHIFT;
                end
            end
            S_NORM_SHIFT: begin
                norm_d  = norm_q + CW'(1);
                state_d = S_NORM_CHK;
            end
            S_SEL: begin
                digit_d = sel_digit;
                state_d = S_SHIFT;
            end
            S_SHIFT:      state_d = S_ADD;
            S_ADD: begin
                iter_d  = iter_q + IW'(1);
                state_d = (iter_q == IW'(N_ITER - 1)) ? S_CORR : S_SEL;
            end
            S_CORR:       state_d = S_QUOT;
            S_QUOT: begin
                den_d   = norm_q;
                state_d = S_DENORM_CHK;
            end
            S_DENORM_CHK: state_d = (den_q != '0) ? S_DENORM_SHIFT : S_DONE;
            S_DENORM_SHIFT: begin
                den_d   = den_q - CW'(1);
                state_d = S_DENORM_CHK;
            end
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        // Pulses are decoded from the next state so they appear with it, one cycle wide
        case (state_d)
            S_INIT: begin
                c_d[C0] = 1'b1;
                c_d[C1] = 1'b1;
            end
            S_NORM_SHIFT:   c_d[C2] = 1'b1;
            S_SHIFT:        c_d = shift_bits(digit_d);
            S_ADD:          c_d = add_bits(digit_d);
            S_CORR: begin
                if (p_sign) begin
                    c_d[C8]  = 1'b1;
                    c_d[C12] = 1'b1;
                end
            end
            S_QUOT:         c_d[C13] = 1'b1;
            S_DENORM_SHIFT: c_d[C14] = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

`ifdef SRT4_CYCLE_COUNT_EN
    // Busy-cycle counter: cleared by an accepted start, frozen once back in IDLE
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && start) begin
            cyc_d = '0;
        end else if (busy_q) begin
            cyc_d = cyc_q + 6'd1;
        end
    end
`endif

    // FSM state and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            norm_q  <= '0;
            den_q   <= '0;
            iter_q  <= '0;
            digit_q <= DIG_ZERO;
`ifdef SRT4_CYCLE_COUNT_EN
            cyc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            norm_q  <= norm_d;
            den_q   <= den_d;
            iter_q  <= iter_d;
            digit_q <= digit_d;
`ifdef SRT4_CYCLE_COUNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    assign c           = c_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
`ifdef SRT4_CYCLE_COUNT_EN
    assign cycle_cnt   = cyc_q;
`endif

endmodule

// File: tb/tb_srt4_control.sv
// Directed bench for srt4_control: digit table plus normalise, divide-by-zero and reset sequences.
// A tiny datapath stand-in raises b_msb after the requested number of c2 shifts and
// presents p_top per iteration (forced to 0 for the last one).
module tb_srt4_control;

    logic        clk;
    logic        rst;
    logic        start;
    logic        b_msb;
    logic [3:0]  p_top;
    logic        p_sign;
    logic [14:0] c;
    logic        busy;
    logic        done;
    logic        div_by_zero;
`ifdef SRT4_CYCLE_COUNT_EN
    logic [5:0]  cycle_cnt;
`endif

    srt4_control dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .b_msb       (b_msb),
        .p_top       (p_top),
        .p_sign      (p_sign),
        .c           (c),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
`ifdef SRT4_CYCLE_COUNT_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    logic [14:0] cap_c   [0:63];
    logic        cap_dbz [0:63];
    int          done_cyc;
    int          n_c2, n_c3, n_c8, n_c13, n_c14;
    int          viol;
    int          busy_err;
    int          done_cc;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one operation; start is high in cycle 0. abort_at >= 0 asserts rst in that cycle.
    task automatic run_op(input logic [3:0] ptop, input logic psign, input int shifts,
                          input int abort_at);
        @(posedge clk);
        #1;
        done_cyc = -1;
        n_c2 = 0; n_c3 = 0; n_c8 = 0; n_c13 = 0; n_c14 = 0;
        viol = 0; busy_err = 0; done_cc = -1;
        for (int i = 0; i < 64; i++) begin
            cap_c[i]   = '0;
            cap_dbz[i] = 1'b0;
        end
        cap_c[0]   = c;
        cap_dbz[0] = div_by_zero;
        if (busy !== 1'b0) busy_err++;
        start  = 1'b1;
        b_msb  = (shifts == 0);
        p_top  = ptop;
        p_sign = psign;
        for (int k = 1; k < 64; k++) begin
            @(posedge clk);
            #1;
            start      = 1'b0;
            cap_c[k]   = c;
            cap_dbz[k] = div_by_zero;
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_c", int'(c), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                return;
            end
            if (c[2])  n_c2++;
            if (c[3])  n_c3++;
            if (c[8])  n_c8++;
            if (c[13]) n_c13++;
            if (c[14]) n_c14++;
            if ((c & cap_c[k-1]) != 15'd0) viol++;
            if (c[11]) viol++;
            if (c[8] && c[13]) viol++;
            if (busy !== 1'b1) busy_err++;
            if (done === 1'b1) begin
                done_cyc = k;
`ifdef SRT4_CYCLE_COUNT_EN
                done_cc = int'(cycle_cnt);
`endif
                break;
            end
            b_msb = (n_c2 >= shifts);
            p_top = (n_c3 < 3) ? ptop : 4'h0;
        end
        if (done_cyc < 0) chk("done_timeout", done_cyc, 0);
    endtask

    typedef struct {
        logic [3:0]  ptop;
        logic        psign;
        logic [14:0] exp_shift;
        logic [14:0] exp_add;
        logic [14:0] exp_corr;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        start = 1'b0;
        b_msb = 1'b0;
        p_top = 4'h0;
        p_sign = 1'b0;

        // {p_top, p_sign, SHIFT c, ADD c, CORR c}; bits: c3=0x8 c4=0x10 c5=0x20 c6=0x40
        // c7=0x80 c8=0x100 c9=0x200 c10=0x400 c12=0x1000
        vecs[0] = '{4'h0, 1'b0, 15'h0008, 15'h0000, 15'h0000};
        vecs[1] = '{4'h3, 1'b0, 15'h0088, 15'h0700, 15'h0000};
        vecs[2] = '{4'h2, 1'b0, 15'h0088, 15'h0700, 15'h0000};
        vecs[3] = '{4'h1, 1'b0, 15'h0018, 15'h0300, 15'h0000};
        vecs[4] = '{4'hF, 1'b1, 15'h0008, 15'h0000, 15'h1100};
        vecs[5] = '{4'hE, 1'b1, 15'h0028, 15'h0100, 15'h1100};
        vecs[6] = '{4'hD, 1'b0, 15'h0048, 15'h0500, 15'h0000};
        vecs[7] = '{4'h8, 1'b1, 15'h0048, 15'h0500, 15'h1100};
        vecs[8] = '{4'h7, 1'b0, 15'h0088, 15'h0700, 15'h0000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_c", int'(c), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        rst = 1'b0;

        // Digit selection table, no normalisation
        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].ptop, vecs[v].psign, 0, -1);
            chk("tbl_done_cycle", done_cyc, 18);
            chk("tbl_init_c", int'(cap_c[1]), 32'h3);
            chk("tbl_shift_it0", int'(cap_c[4]), int'(vecs[v].exp_shift));
            chk("tbl_add_it0", int'(cap_c[5]), int'(vecs[v].exp_add));
            chk("tbl_shift_it1", int'(cap_c[7]), int'(vecs[v].exp_shift));
            chk("tbl_shift_last", int'(cap_c[13]), 32'h8);
            chk("tbl_add_last", int'(cap_c[14]), 0);
            chk("tbl_corr", int'(cap_c[15]), int'(vecs[v].exp_corr));
            chk("tbl_quot", int'(cap_c[16]), 32'h2000);
            chk("tbl_c3_count", n_c3, 4);
            chk("tbl_c2_c14", n_c2 + n_c14, 0);
            chk("tbl_pulse_rules", viol, 0);
            chk("tbl_busy", busy_err, 0);
            chk("tbl_dbz", int'(cap_dbz[18]), 0);
`ifdef SRT4_CYCLE_COUNT_EN
            chk("tbl_cycle_cnt", done_cc, 17);
`endif
        end

        // Three normalisation shifts, mirrored by three denormalisation shifts
        run_op(4'h0, 1'b0, 3, -1);
        chk("norm3_done_cycle", done_cyc, 30);
        chk("norm3_c2_count", n_c2, 3);
        chk("norm3_c14_count", n_c14, 3);
        chk("norm3_c2_cyc3", int'(cap_c[3]), 32'h4);
        chk("norm3_gap_cyc4", int'(cap_c[4]), 0);
        chk("norm3_c2_cyc7", int'(cap_c[7]), 32'h4);
        chk("norm3_quot_cyc22", int'(cap_c[22]), 32'h2000);
        chk("norm3_c14_cyc24", int'(cap_c[24]), 32'h4000);
        chk("norm3_c14_cyc28", int'(cap_c[28]), 32'h4000);
        chk("norm3_gap_cyc29", int'(cap_c[29]), 0);
        chk("norm3_pulse_rules", viol, 0);
        chk("norm3_busy", busy_err, 0);

        // Divide by zero: b_msb never rises
        run_op(4'h3, 1'b0, 99, -1);
        chk("dbz_done_cycle", done_cyc, 17);
        chk("dbz_c2_count", n_c2, 7);
        chk("dbz_c3_count", n_c3, 0);
        chk("dbz_c13_count", n_c13, 0);
        chk("dbz_flag", int'(cap_dbz[17]), 1);
        chk("dbz_pulse_rules", viol, 0);
        @(posedge clk);
        #1;
        chk("dbz_held", int'(div_by_zero), 1);
        chk("dbz_done_pulse", int'(done), 0);
        chk("dbz_busy_after", int'(busy), 0);

        // Next start clears the flag and runs normally
        run_op(4'h3, 1'b0, 0, -1);
        chk("after_dbz_clear", int'(cap_dbz[1]), 0);
        chk("after_dbz_done_cycle", done_cyc, 18);
        chk("after_dbz_flag", int'(cap_dbz[18]), 0);

        // Reset during iteration 2 (SHIFT in cycle 10), then a clean run
        run_op(4'h1, 1'b0, 0, 10);
        chk("abort_pre_c", int'(cap_c[10]), 32'h18);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(4'h0, 1'b0, 0, -1);
        chk("post_abort_done_cycle", done_cyc, 18);
        chk("post_abort_init", int'(cap_c[1]), 32'h3);
        chk("post_abort_c3_count", n_c3, 4);
        chk("post_abort_c8_count", n_c8, 0);
        chk("post_abort_pulse_rules", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
